// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit framing path.
//   IDLE / COLLECT    : framer state encodings
//   err_code_t, ERR_* : error cause codes reported with o_err
//   frame_bytes()     : bytes in one ALU command frame (A, B, opcode)
package uart_pkg;

    localparam logic IDLE    = 1'b0;
    localparam logic COLLECT = 1'b1;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_TIMEOUT = 2'b01;
    localparam err_code_t ERR_FRAME   = 2'b10;
    localparam err_code_t ERR_OVERRUN = 2'b11;

    function automatic int unsigned frame_bytes(input int unsigned op_bytes);
        return 2 * op_bytes + 1;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: saturating idle-gap counter.
//   i_clk, i_rst : clock, synchronous active-low reset
//   i_clear      : restart the gap (priority over i_en)
//   i_en         : count one idle cycle
//   o_expire     : high in the idle cycle that brings the gap to TIMEOUT_CYC
// TIMEOUT_CYC = 0 disables expiry entirely.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST  = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires combinationally on the idle cycle whose increment would reach
    // TIMEOUT_CYC, so the owner reacts on that same edge.
    assign o_expire = (TIMEOUT_CYC != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_alu_framer.sv
// uart_rx_alu_framer: packs received UART bytes into one ALU command frame
// (operand A, operand B, opcode; operands little-endian) and presents it in
// a one-entry output slot with a valid/ready handshake.
//   i_clk, i_rst   : clock, synchronous active-low reset
//   i_data         : received byte, valid with i_done_data
//   i_done_data    : byte-received strobe
//   i_rx_err       : receiver framing/parity error strobe
//   i_ready        : ALU accepts the slot this cycle
//   o_a, o_b, o_op : command slot contents
//   o_valid        : slot occupied
//   o_err          : one-cycle error pulse, cause in o_err_code (held)
//   o_busy         : a frame is partially collected
module uart_rx_alu_framer
    import uart_pkg::*;
#(
    parameter int unsigned DBIT        = 8,
    parameter int unsigned OP_BYTES    = 2,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DBIT-1:0]          i_data,
    input  logic                     i_done_data,
    input  logic                     i_rx_err,
    input  logic                     i_ready,
    output logic [OP_BYTES*DBIT-1:0] o_a,
    output logic [OP_BYTES*DBIT-1:0] o_b,
    output logic [DBIT-1:0]          o_op,
    output logic                     o_valid,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic                     o_busy
);

    localparam int unsigned FRAME_BYTES = frame_bytes(OP_BYTES);
    localparam int unsigned OP_W        = OP_BYTES * DBIT;
    localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

    logic             r_state;
    logic [IDX_W-1:0] r_idx;
    logic [OP_W-1:0]  r_sh_a;
    logic [OP_W-1:0]  r_sh_b;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [DBIT-1:0]  r_op;
    logic             r_valid;
    logic             r_err;
    err_code_t        r_err_code;

    logic w_collect;
    logic w_strobe;
    logic w_slot_free;
    logic w_expire;

    assign w_collect   = (r_state == COLLECT);
    // An error in the same cycle as a byte discards that byte.
    assign w_strobe    = i_done_data & ~i_rx_err;
    assign w_slot_free = ~r_valid | i_ready;

    uart_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (~w_collect | i_done_data | i_rx_err),
        .i_en    (w_collect & ~i_done_data & ~i_rx_err),
        .o_expire(w_expire)
    );

    // Shadow capture: r_idx is 0 in IDLE, so the first byte lands at index 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
        end else if (w_strobe) begin
            for (int unsigned k = 0; k < OP_BYTES; k++) begin
                if (r_idx == IDX_W'(k))
                    r_sh_a[DBIT*k +: DBIT] <= i_data;
                if (r_idx == IDX_W'(k + OP_BYTES))
                    r_sh_b[DBIT*k +: DBIT] <= i_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_err <= 1'b0;
            // Consumption; a load later in this block takes precedence.
            if (r_valid && i_ready)
                r_valid <= 1'b0;

            if (r_state == IDLE) begin
                if (i_rx_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_FRAME;
                end else if (i_done_data) begin
                    r_state <= COLLECT;
                    r_idx   <= IDX_W'(1);
                end
            end else begin
                if (i_rx_err) begin
                    r_state    <= IDLE;
                    r_idx      <= '0;
                    r_err      <= 1'b1;
                    r_err_code <= ERR_FRAME;
                end else if (i_done_data) begin
                    if (r_idx == IDX_LAST) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        if (w_slot_free) begin
                            // Opcode bypasses the shadows; operands are complete.
                            r_a     <= r_sh_a;
                            r_b     <= r_sh_b;
                            r_op    <= i_data;
                            r_valid <= 1'b1;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_OVERRUN;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end else if (w_expire) begin
                    r_state    <= IDLE;
                    r_idx      <= '0;
                    r_err      <= 1'b1;
                    r_err_code <= ERR_TIMEOUT;
                end
            end
        end
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_op       = r_op;
    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_busy     = w_collect;

endmodule

// File: tb/tb_uart_rx_alu_framer.sv
// tb_uart_rx_alu_framer: directed and randomized checks of uart_rx_alu_framer.
// Two instances share stimulus: u_dut (TIMEOUT_CYC=50) and u_dut_nt
// (TIMEOUT_CYC=0). A frame-level reference model per instance predicts every
// output after every clock edge.
module tb_uart_rx_alu_framer;

    localparam int unsigned DBIT = 8;
    localparam int unsigned OPB  = 2;
    localparam int unsigned FB   = 2 * OPB + 1;
    localparam int unsigned OPW  = OPB * DBIT;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic [DBIT-1:0] i_data = '0;
    logic            i_done_data = 1'b0;
    logic            i_rx_err = 1'b0;
    logic            i_ready = 1'b0;

    logic [OPW-1:0]  a0, b0, a1, b1;
    logic [DBIT-1:0] op0, op1;
    logic            v0, e0, bz0, v1, e1, bz1;
    logic [1:0]      c0, c1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    uart_rx_alu_framer #(
        .DBIT(DBIT), .OP_BYTES(OPB), .TIMEOUT_CYC(50)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_done_data(i_done_data),
        .i_rx_err(i_rx_err), .i_ready(i_ready), .o_a(a0), .o_b(b0), .o_op(op0),
        .o_valid(v0), .o_err(e0), .o_err_code(c0), .o_busy(bz0)
    );

    uart_rx_alu_framer #(
        .DBIT(DBIT), .OP_BYTES(OPB), .TIMEOUT_CYC(0)
    ) u_dut_nt (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_done_data(i_done_data),
        .i_rx_err(i_rx_err), .i_ready(i_ready), .o_a(a1), .o_b(b1), .o_op(op1),
        .o_valid(v1), .o_err(e1), .o_err_code(c1), .o_busy(bz1)
    );

    // Reference model state, one slot per instance.
    int              m_cnt   [2];
    logic [DBIT-1:0] m_byte  [2][FB];
    int              m_gap   [2];
    bit              m_valid [2];
    logic [OPW-1:0]  m_a     [2];
    logic [OPW-1:0]  m_b     [2];
    logic [DBIT-1:0] m_op    [2];
    bit              m_err   [2];
    logic [1:0]      m_code  [2];

    function automatic int timeout_of(input int m);
        return (m == 0) ? 50 : 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input bit rst, input bit done,
                              input logic [DBIT-1:0] data, input bit rx, input bit rdy);
        bit cons;
        bit ld;
        if (!rst) begin
            m_cnt[m] = 0; m_gap[m] = 0; m_valid[m] = 0;
            m_a[m] = '0; m_b[m] = '0; m_op[m] = '0;
            m_err[m] = 0; m_code[m] = 2'b00;
            return;
        end
        cons = m_valid[m] && rdy;
        ld = 0;
        m_err[m] = 0;
        if (rx) begin
            m_cnt[m] = 0; m_gap[m] = 0;
            m_err[m] = 1; m_code[m] = 2'b10;
        end else if (done) begin
            m_byte[m][m_cnt[m]] = data;
            m_cnt[m]++;
            m_gap[m] = 0;
            if (m_cnt[m] == FB) begin
                m_cnt[m] = 0;
                if (!m_valid[m] || rdy) begin
                    ld = 1;
                    m_a[m] = '0;
                    m_b[m] = '0;
                    for (int k = 0; k < OPB; k++) begin
                        m_a[m] = m_a[m] | (OPW'(m_byte[m][k]) << (DBIT * k));
                        m_b[m] = m_b[m] | (OPW'(m_byte[m][k + OPB]) << (DBIT * k));
                    end
                    m_op[m] = m_byte[m][FB-1];
                end else begin
                    m_err[m] = 1; m_code[m] = 2'b11;
                end
            end
        end else if (m_cnt[m] > 0) begin
            m_gap[m]++;
            if (timeout_of(m) != 0 && m_gap[m] == timeout_of(m)) begin
                m_cnt[m] = 0; m_gap[m] = 0;
                m_err[m] = 1; m_code[m] = 2'b01;
            end
        end
        if (ld) m_valid[m] = 1;
        else if (cons) m_valid[m] = 0;
    endtask

    task automatic compare_dut(input int m);
        logic [31:0] a, b, op, v, e, c, bz;
        if (m == 0) begin
            a = 32'(a0); b = 32'(b0); op = 32'(op0); v = 32'(v0); e = 32'(e0); c = 32'(c0); bz = 32'(bz0);
        end else begin
            a = 32'(a1); b = 32'(b1); op = 32'(op1); v = 32'(v1); e = 32'(e1); c = 32'(c1); bz = 32'(bz1);
        end
        check_val($sformatf("d%0d_o_a", m), a, 32'(m_a[m]));
        check_val($sformatf("d%0d_o_b", m), b, 32'(m_b[m]));
        check_val($sformatf("d%0d_o_op", m), op, 32'(m_op[m]));
        check_val($sformatf("d%0d_o_valid", m), v, 32'(m_valid[m]));
        check_val($sformatf("d%0d_o_err", m), e, 32'(m_err[m]));
        check_val($sformatf("d%0d_o_err_code", m), c, 32'(m_code[m]));
        check_val($sformatf("d%0d_o_busy", m), bz, 32'(m_cnt[m] > 0));
    endtask

    // One clock: drive inputs, advance both models, sample 1 time unit after the edge.
    task automatic tick(input bit rst, input bit done, input logic [DBIT-1:0] data,
                        input bit rx, input bit rdy);
        i_rst = rst; i_done_data = done; i_data = data; i_rx_err = rx; i_ready = rdy;
        model_step(0, rst, done, data, rx, rdy);
        model_step(1, rst, done, data, rx, rdy);
        @(posedge i_clk);
        #1;
        compare_dut(0);
        compare_dut(1);
    endtask

    task automatic send(input logic [DBIT-1:0] data, input bit rdy);
        tick(1'b1, 1'b1, data, 1'b0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, 1'b0, rdy);
    endtask

    initial begin
        // Reset
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("rst_valid", 32'(v0), 32'd0);
        check_val("rst_busy", 32'(bz0), 32'd0);
        idle(2, 1'b1);

        // Basic frame
        send(8'h34, 1'b1); send(8'h12, 1'b1); send(8'h78, 1'b1); send(8'h56, 1'b1);
        send(8'h20, 1'b1);
        check_val("basic_valid", 32'(v0), 32'd1);
        check_val("basic_a", 32'(a0), 32'h1234);
        check_val("basic_b", 32'(b0), 32'h5678);
        check_val("basic_op", 32'(op0), 32'h20);
        idle(1, 1'b1);
        check_val("basic_drop", 32'(v0), 32'd0);

        // Backpressure and overrun
        send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        idle(1, 1'b0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        check_val("ovr_err", 32'(e0), 32'd1);
        check_val("ovr_code", 32'(c0), 32'd3);
        check_val("ovr_a_kept", 32'(a0), 32'h0001);
        idle(1, 1'b0);
        check_val("ovr_err_1cyc", 32'(e0), 32'd0);
        send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0); send(8'h99, 1'b0);
        send(8'hAB, 1'b1);
        check_val("swap_valid", 32'(v0), 32'd1);
        check_val("swap_a", 32'(a0), 32'h7766);
        check_val("swap_op", 32'(op0), 32'hAB);
        idle(2, 1'b1);

        // Timeout
        send(8'hE1, 1'b1); send(8'hE2, 1'b1);
        idle(49, 1'b1);
        check_val("to_not_yet", 32'(e0), 32'd0);
        idle(1, 1'b1);
        check_val("to_err", 32'(e0), 32'd1);
        check_val("to_code", 32'(c0), 32'd1);
        check_val("to_busy", 32'(bz0), 32'd0);
        send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b1); send(8'hDD, 1'b1);
        send(8'h01, 1'b1);
        check_val("to_a", 32'(a0), 32'hBBAA);
        check_val("to_b", 32'(b0), 32'hDDCC);
        check_val("to_op", 32'(op0), 32'h01);
        idle(2, 1'b1);

        // Framing error on the third byte
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        send(8'h01, 1'b1); send(8'h02, 1'b1);
        tick(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
        check_val("fe_err", 32'(e0), 32'd1);
        check_val("fe_code", 32'(c0), 32'd2);
        check_val("fe_valid", 32'(v0), 32'd0);
        idle(1, 1'b1);
        send(8'h10, 1'b1); send(8'h20, 1'b1); send(8'h30, 1'b1); send(8'h40, 1'b1);
        send(8'h50, 1'b1);
        check_val("fe_a", 32'(a0), 32'h2010);
        check_val("fe_b", 32'(b0), 32'h4030);
        idle(1, 1'b1);

        // Reset mid-frame with a full slot
        send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        send(8'hC5, 1'b0);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("mrst_valid", 32'(v0), 32'd0);
        check_val("mrst_a", 32'(a0), 32'd0);
        check_val("mrst_busy", 32'(bz0), 32'd0);
        send(8'h21, 1'b1); send(8'h43, 1'b1); send(8'h65, 1'b1); send(8'h87, 1'b1);
        send(8'h09, 1'b1);
        check_val("mrst_new_a", 32'(a0), 32'h4321);
        check_val("mrst_new_b", 32'(b0), 32'h8765);
        idle(1, 1'b1);

        // Disabled timeout: long gap on the TIMEOUT_CYC=0 instance
        tick(1'b0, 1'b0, '0, 1'b0, 1'b1);
        send(8'h11, 1'b1);
        idle(10000, 1'b1);
        send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1); send(8'h55, 1'b1);
        check_val("nt_valid", 32'(v1), 32'd1);
        check_val("nt_a", 32'(a1), 32'h2211);
        check_val("nt_b", 32'(b1), 32'h4433);
        check_val("nt_op", 32'(op1), 32'h55);
        check_val("nt_code", 32'(c1), 32'd0);
        idle(2, 1'b1);

        // Randomized traffic: alternating dense and sparse byte phases
        for (int blk = 0; blk < 8; blk++) begin
            int p_done;
            p_done = (blk % 2 == 0) ? 35 : 3;
            for (int i = 0; i < 500; i++) begin
                bit r_rst, r_done, r_rx, r_rdy;
                logic [DBIT-1:0] r_data;
                r_rst  = ($urandom_range(0, 999) >= 2);
                r_done = ($urandom_range(0, 99) < p_done);
                r_rx   = ($urandom_range(0, 99) < 2);
                r_rdy  = ($urandom_range(0, 99) < 50);
                r_data = DBIT'($urandom);
                tick(r_rst, r_done, r_data, r_rx, r_rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
